// File: rtl/ann_pkg.sv
// Shared constants and types for the ANN search datapath.
package ann_pkg;
  localparam int DATA_WIDTH = 11;
  localparam int ROW_SIZE   = 26;
  localparam int COL_SIZE   = 19;
  localparam int BLOCKING   = 4;
  localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sender_state_t;
endpackage

// File: rtl/best_arr_addr_gen.sv
// Walks the best-index array in blocked order: half-image, column block, row, column-in-block.
module best_arr_addr_gen #(
  parameter int ROW_SIZE = ann_pkg::ROW_SIZE,
  parameter int COL_SIZE = ann_pkg::COL_SIZE,
  parameter int BLOCKING = ann_pkg::BLOCKING,
  parameter int ADDR_W   = $clog2(ROW_SIZE * COL_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  import ann_pkg::*;

  localparam int YW  = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int XIW = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;
  localparam logic [ADDR_W-1:0] HALF_A = ADDR_W'(ROW_SIZE / 2);
  localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(ROW_SIZE);
  localparam logic [ADDR_W-1:0] BLK_A  = ADDR_W'(BLOCKING);

  logic           px;
  logic [1:0]     x;
  logic [YW-1:0]  y;
  logic [XIW-1:0] xi;
  logic           xi_wrap;
  logic           y_wrap;
  logic           x_wrap;

  // The last column block only holds one column, so xi wraps immediately there.
  always_comb begin
    x_wrap  = (x == 2'd3);
    y_wrap  = (y == YW'(COL_SIZE - 1));
    xi_wrap = x_wrap || (xi == XIW'(BLOCKING - 1));
    last    = px && x_wrap && y_wrap && (xi == '0);
    addr    = (px ? HALF_A : '0) + ADDR_W'(y) * ROW_A + ADDR_W'(x) * BLK_A + ADDR_W'(xi);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px <= 1'b0;
      x  <= '0;
      y  <= '0;
      xi <= '0;
    end else if (step) begin
      if (!xi_wrap) begin
        xi <= xi + 1'b1;
      end else begin
        xi <= '0;
        if (!y_wrap) begin
          y <= y + 1'b1;
        end else begin
          y <= '0;
          if (!x_wrap) begin
            x <= x + 1'b1;
          end else begin
            x  <= '0;
            px <= ~px;
          end
        end
      end
    end
  end
endmodule

// File: rtl/best_arr_sender.sv
// Streams the best-index array into the output FIFO through a 2-entry credit-controlled skid buffer.
module best_arr_sender #(
  parameter int DATA_WIDTH = ann_pkg::DATA_WIDTH,
  parameter int ROW_SIZE   = ann_pkg::ROW_SIZE,
  parameter int COL_SIZE   = ann_pkg::COL_SIZE,
  parameter int BLOCKING   = ann_pkg::BLOCKING,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDR_W     = $clog2(NUM_QUERYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send_best_arr,
  output logic                  busy,
  output logic                  done,
  output logic                  best_ren,
  output logic [ADDR_W-1:0]     best_raddr,
  input  logic [DATA_WIDTH-1:0] best_rdata,
  output logic                  out_fifo_wenq,
  output logic [DATA_WIDTH-1:0] out_fifo_wdata,
  input  logic                  out_fifo_wfull_n
);
  import ann_pkg::*;

  sender_state_t         state;
  logic [1:0]            count;
  logic                  inflight;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DATA_WIDTH-1:0] hold_mem [2];
  logic                  last;
  logic [ADDR_W-1:0]     addr;

  best_arr_addr_gen #(
    .ROW_SIZE (ROW_SIZE),
    .COL_SIZE (COL_SIZE),
    .BLOCKING (BLOCKING),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (best_ren),
    .addr  (addr),
    .last  (last)
  );

  // A read is only issued when its data is guaranteed a slot, even if the FIFO stalls next cycle.
  assign out_fifo_wenq  = (count != 2'd0) && out_fifo_wfull_n;
  assign out_fifo_wdata = hold_mem[rd_ptr];
  assign best_ren       = (state == RUN) &&
                          ((3'(count) + 3'(inflight) - 3'(out_fifo_wenq)) < 3'd2);
  assign best_raddr     = addr;
  assign busy           = (state != IDLE);
  assign done           = (state == DRAIN) && (count == 2'd0) && !inflight;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 2'd0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      hold_mem[0] <= '0;
      hold_mem[1] <= '0;
    end else begin
      inflight <= best_ren;
      if (inflight) begin
        hold_mem[wr_ptr] <= best_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (out_fifo_wenq) rd_ptr <= ~rd_ptr;
      count <= count + 2'(inflight) - 2'(out_fifo_wenq);
      case (state)
        IDLE:    if (send_best_arr) state <= RUN;
        RUN:     if (best_ren && last) state <= DRAIN;
        DRAIN:   if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
